rx_demux: RTL



---
 rtl/rx_demux.sv | 87 ++++++++
 1 files changed

// File: rtl/rx_demux.sv
// rx_demux: pops header/MSB/LSB frames from the RX FIFO and hands the
// reassembled 16-bit word to the addressed consumer over a valid/ack handshake.
module rx_demux #(
    parameter int ACK_TIMEOUT = 0,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rdata,
    input  logic             rempty,
    output logic             rinc,
    output logic [15:0]      out,
    output logic [3:0]       valid,
    input  logic [3:0]       ack,
    output logic [ERR_W-1:0] err_count
);
    localparam int TW = $clog2(ACK_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        HDR_WAIT, HDR_POP, MSB_WAIT, MSB_POP, LSB_WAIT, LSB_POP, OUT_WAIT, OUT_DONE
    } state_t;

    state_t           state_q;
    logic [1:0]       sel_q;
    logic [15:0]      out_q;
    logic [3:0]       valid_q;
    logic [ERR_W-1:0] err_q, err_d;
    logic [TW-1:0]    tmo_q;
    logic             ack_sel, tmo_hit, err_inc;

    assign ack_sel = ack[sel_q];
    assign tmo_hit = (ACK_TIMEOUT > 0) && (tmo_q == TW'(ACK_TIMEOUT - 1));
    // Bad header and ack timeout live in different states, so at most one +1 per cycle.
    assign err_inc = (state_q == HDR_POP && rdata[7:2] != 6'd0) ||
                     (state_q == OUT_WAIT && !ack_sel && tmo_hit);
    assign err_d   = (err_inc && err_q != '1) ? err_q + ERR_W'(1) : err_q;

    assign rinc      = state_q inside {HDR_POP, MSB_POP, LSB_POP};
    assign out       = out_q;
    assign valid     = valid_q;
    assign err_count = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HDR_WAIT;
            sel_q   <= '0;
            out_q   <= '0;
            valid_q <= '0;
            err_q   <= '0;
            tmo_q   <= '0;
        end else begin
            err_q <= err_d;
            case (state_q)
                HDR_WAIT: if (!rempty) state_q <= HDR_POP;
                HDR_POP: begin
                    if (rdata[7:2] == 6'd0) begin
                        sel_q   <= rdata[1:0];
                        state_q <= MSB_WAIT;
                    end else begin
                        state_q <= HDR_WAIT;
                    end
                end
                MSB_WAIT: if (!rempty) state_q <= MSB_POP;
                MSB_POP: begin
                    out_q[15:8] <= rdata;
                    state_q     <= LSB_WAIT;
                end
                LSB_WAIT: if (!rempty) state_q <= LSB_POP;
                LSB_POP: begin
                    out_q[7:0] <= rdata;
                    valid_q    <= 4'b0001 << sel_q;
                    tmo_q      <= '0;
                    state_q    <= OUT_WAIT;
                end
                OUT_WAIT: begin
                    tmo_q <= tmo_q + TW'(1);
                    if (ack_sel || tmo_hit) begin
                        valid_q <= '0;
                        state_q <= OUT_DONE;
                    end
                end
                OUT_DONE: if (!ack_sel) state_q <= HDR_WAIT;
                default:  state_q <= HDR_WAIT;
            endcase
        end
    end
endmodule
